udi_sqmag_dp: RTL



---
 rtl/udi_pkg.sv | 19 +
 rtl/udi_sq16.sv | 16 +
 rtl/udi_sqmag_dp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/udi_pkg.sv
// Shared definitions for the squared-magnitude UDI datapath.
// Holds the function codes and the fixed operand/result widths.
package udi_pkg;

    localparam int UDI_OPW = 16;
    localparam int UDI_RW  = 32;

    typedef enum logic [2:0] {
        UDI_F_SUM       = 3'd0,
        UDI_F_SUMSH     = 3'd1,
        UDI_F_SQ        = 3'd2,
        UDI_F_THRWR     = 3'd3,
        UDI_F_CMP_SUM   = 3'd4,
        UDI_F_CMP_SUMSH = 3'd5,
        UDI_F_CMP_SQ    = 3'd6,
        UDI_F_RSVD      = 3'd7
    } udi_func_e;

endpackage

// File: rtl/udi_sq16.sv
// Combinational 16-bit signed squarer with a 32-bit unsigned result.
// Ports: a (signed operand in), sq (a*a, at most 2^30, out).
module udi_sq16
    import udi_pkg::*;
(
    input  logic [UDI_OPW-1:0] a,
    output logic [UDI_RW-1:0]  sq
);

    logic signed [UDI_RW-1:0] prod;

    // Operands sign-extend to 32 bits from the assignment context.
    assign prod = $signed(a) * $signed(a);
    assign sq   = prod;

endmodule

// File: rtl/udi_sqmag_dp.sv
// Two-stage squared-magnitude UDI datapath with a threshold register.
// Ports: UDI_gclk/UDI_greset (sync, active-high), UDI_gscanenable (unused),
//   dp_issue_e/dp_func_e/dp_rs_e/dp_rt_e (E-stage op), dp_kill_m (kills
//   stage 1), dp_stall_m, dp_rd_m/dp_rd_valid (result), dp_thr (threshold).
module udi_sqmag_dp
    import udi_pkg::*;
(
    input  logic               UDI_gclk,
    input  logic               UDI_greset,
    input  logic               UDI_gscanenable,
    input  logic               dp_issue_e,
    input  logic [2:0]         dp_func_e,
    input  logic [UDI_RW-1:0]  dp_rs_e,
    input  logic [UDI_OPW-1:0] dp_rt_e,
    input  logic               dp_kill_m,
    output logic               dp_stall_m,
    output logic [UDI_RW-1:0]  dp_rd_m,
    output logic               dp_rd_valid,
    output logic [UDI_RW-1:0]  dp_thr
);

    logic [UDI_RW-1:0] sq_s_e;
    logic [UDI_RW-1:0] sq_t_e;
    logic              issue_ok;

    logic              s1_valid;
    udi_func_e         s1_func;
    logic [UDI_RW-1:0] s1_sq_s;
    logic [UDI_RW-1:0] s1_sq_t;
    logic [UDI_RW-1:0] s1_thr_data;

    logic              s1_live;
    logic              s1_wr;
    logic              s1_cmp;
    logic [UDI_RW-1:0] sum;
    logic [UDI_RW-1:0] base;
    logic [UDI_RW-1:0] result;

    logic              unused_scan;
    assign unused_scan = UDI_gscanenable;

    udi_sq16 u_sq_s (
        .a  (dp_rs_e[31:16]),
        .sq (sq_s_e)
    );

    udi_sq16 u_sq_t (
        .a  (dp_rt_e),
        .sq (sq_t_e)
    );

    // Reserved code behaves as a bubble: it never enters stage 1.
    assign issue_ok = dp_issue_e && (dp_func_e != UDI_F_RSVD);

    // Stage 1 (M1)
    always_ff @(posedge UDI_gclk) begin
        if (UDI_greset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= issue_ok;
        end
        if (issue_ok) begin
            s1_func     <= udi_func_e'(dp_func_e);
            s1_sq_s     <= sq_s_e;
            s1_sq_t     <= sq_t_e;
            s1_thr_data <= dp_rs_e;
        end
    end

    assign s1_live    = s1_valid && !dp_kill_m;
    assign s1_wr      = (s1_func == UDI_F_THRWR);
    assign dp_stall_m = s1_valid && !s1_wr && !dp_kill_m;

    // Squares are at most 2^30 each, so the 32-bit sum cannot overflow.
    assign sum = s1_sq_s + s1_sq_t;

    always_comb begin
        base   = '0;
        s1_cmp = 1'b0;
        unique case (s1_func)
            UDI_F_SUM:       base = sum;
            UDI_F_SUMSH:     base = sum >> 1;
            UDI_F_SQ:        base = s1_sq_s;
            UDI_F_CMP_SUM: begin
                base   = sum;
                s1_cmp = 1'b1;
            end
            UDI_F_CMP_SUMSH: begin
                base   = sum >> 1;
                s1_cmp = 1'b1;
            end
            UDI_F_CMP_SQ: begin
                base   = s1_sq_s;
                s1_cmp = 1'b1;
            end
            default:         base = '0;
        endcase
    end

    // Compare reads the threshold register as it stands this cycle, so a
    // THRWR still in stage 1 does not affect an older CMP.
    assign result = s1_cmp ? {31'd0, (base > dp_thr)} : base;

    // Stage 2 (M2)
    always_ff @(posedge UDI_gclk) begin
        if (UDI_greset) begin
            dp_rd_m     <= '0;
            dp_rd_valid <= 1'b0;
            dp_thr      <= '0;
        end else begin
            dp_rd_valid <= s1_live && !s1_wr;
            if (s1_live && !s1_wr) begin
                dp_rd_m <= result;
            end
            if (s1_live && s1_wr) begin
                dp_thr <= s1_thr_data;
            end
        end
    end

endmodule
